// File: rtl/reg_writeback_queue.sv
// Writeback FIFO in front of the 16x16 register bank write port. It issues at most
// one write per cycle and forwards still-pending results to both operand lookups.
module reg_writeback_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_dado,
  input  logic              wr_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_dado,
  input  logic [ADDR_W-1:0] lk_regA,
  input  logic [ADDR_W-1:0] lk_regB,
  output logic              fwd_hitA,
  output logic [DATA_W-1:0] fwd_dataA,
  output logic              fwd_hitB,
  output logic [DATA_W-1:0] fwd_dataB,
  output logic [ADDR_W:0]   count
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_reg_mem [DEPTH];
  logic [DATA_W-1:0] r_dat_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [ADDR_W:0]   r_count;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_reg;
  logic [DATA_W-1:0] r_wr_dado;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_hit_a;
  logic              w_hit_b;
  logic [DATA_W-1:0] w_dat_a;
  logic [DATA_W-1:0] w_dat_b;
  logic [PTR_W-1:0]  w_idx;
  logic              w_live;

  // in_ready ignores a same-edge pop, so a full queue never takes a push
  assign w_full = (r_count == FULL_CNT);
  assign w_push = in_valid && !w_full;
  assign w_pop  = (r_count != {(ADDR_W + 1){1'b0}}) && !wr_stall;

  // Entry storage, written at the tail on an accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_reg_mem[i] <= '0;
        r_dat_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_reg_mem[r_tail] <= in_reg;
      r_dat_mem[r_tail] <= in_dado;
    end
  end

  // Head/tail pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue stage: wr_reg/wr_dado keep their last value while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_dado <= '0;
    end else if (w_pop) begin
      r_wr_en   <= 1'b1;
      r_wr_reg  <= r_reg_mem[r_head];
      r_wr_dado <= r_dat_mem[r_head];
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  // Forwarding: walk oldest (issue stage) to newest (tail), later matches override
  always_comb begin
    w_hit_a = r_wr_en && (r_wr_reg == lk_regA);
    w_dat_a = w_hit_a ? r_wr_dado : {DATA_W{1'b0}};
    w_hit_b = r_wr_en && (r_wr_reg == lk_regB);
    w_dat_b = w_hit_b ? r_wr_dado : {DATA_W{1'b0}};
    w_idx   = r_head;
    w_live  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx   = r_head + PTR_W'(i);
      w_live  = ((ADDR_W + 1)'(i) < r_count);
      w_dat_a = (w_live && (r_reg_mem[w_idx] == lk_regA)) ? r_dat_mem[w_idx] : w_dat_a;
      w_hit_a = (w_live && (r_reg_mem[w_idx] == lk_regA)) ? 1'b1 : w_hit_a;
      w_dat_b = (w_live && (r_reg_mem[w_idx] == lk_regB)) ? r_dat_mem[w_idx] : w_dat_b;
      w_hit_b = (w_live && (r_reg_mem[w_idx] == lk_regB)) ? 1'b1 : w_hit_b;
    end
  end

  assign in_ready  = !w_full;
  assign wr_en     = r_wr_en;
  assign wr_reg    = r_wr_reg;
  assign wr_dado   = r_wr_dado;
  assign count     = r_count;
  assign fwd_hitA  = w_hit_a;
  assign fwd_dataA = w_dat_a;
  assign fwd_hitB  = w_hit_b;
  assign fwd_dataB = w_dat_b;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed scenarios plus randomized traffic for reg_writeback_queue, checked
// against a queue-based reference model of the writeback path.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  r;
    logic [15:0] d;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_reg;
  logic [15:0] in_dado;
  logic        wr_stall;
  logic        wr_en;
  logic [3:0]  wr_reg;
  logic [15:0] wr_dado;
  logic [3:0]  lk_regA;
  logic [3:0]  lk_regB;
  logic        fwd_hitA;
  logic [15:0] fwd_dataA;
  logic        fwd_hitB;
  logic [15:0] fwd_dataB;
  logic [4:0]  count;

  ent_t        mq[$];
  logic        m_wr_en;
  logic [3:0]  m_wr_reg;
  logic [15:0] m_wr_dado;

  int n_cmp;
  int n_fail;

  reg_writeback_queue #(.DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_dado(in_dado),
    .wr_stall(wr_stall), .wr_en(wr_en), .wr_reg(wr_reg), .wr_dado(wr_dado),
    .lk_regA(lk_regA), .lk_regB(lk_regB),
    .fwd_hitA(fwd_hitA), .fwd_dataA(fwd_dataA),
    .fwd_hitB(fwd_hitB), .fwd_dataB(fwd_dataB),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Newest pending write to idx wins; the issue stage is the oldest candidate.
  function automatic void model_fwd(input logic [3:0] idx, output logic hit, output logic [15:0] data);
    bit found;
    found = 1'b0;
    hit   = 1'b0;
    data  = 16'h0000;
    for (int i = int'(mq.size()) - 1; i >= 0; i--) begin
      if (!found && mq[i].r == idx) begin
        found = 1'b1;
        hit   = 1'b1;
        data  = mq[i].d;
      end
    end
    if (!found && m_wr_en && m_wr_reg == idx) begin
      hit  = 1'b1;
      data = m_wr_dado;
    end
  endfunction

  task automatic model_edge();
    bit   pop;
    bit   push;
    ent_t e;
    pop  = (mq.size() > 0) && !wr_stall;
    push = in_valid && (mq.size() < DEPTH);
    if (pop) begin
      e         = mq.pop_front();
      m_wr_en   = 1'b1;
      m_wr_reg  = e.r;
      m_wr_dado = e.d;
    end else begin
      m_wr_en = 1'b0;
    end
    if (push) begin
      e.r = in_reg;
      e.d = in_dado;
      mq.push_back(e);
    end
  endtask

  task automatic check_comb();
    logic        h;
    logic [15:0] d;
    chk("in_ready", in_ready, (mq.size() < DEPTH) ? 1 : 0);
    chk("count_comb", count, mq.size());
    model_fwd(lk_regA, h, d);
    chk("fwd_hitA", fwd_hitA, h);
    chk("fwd_dataA", fwd_dataA, d);
    model_fwd(lk_regB, h, d);
    chk("fwd_hitB", fwd_hitB, h);
    chk("fwd_dataB", fwd_dataB, d);
  endtask

  task automatic check_regs();
    chk("wr_en", wr_en, m_wr_en);
    chk("wr_reg", wr_reg, m_wr_reg);
    chk("wr_dado", wr_dado, m_wr_dado);
    chk("count", count, mq.size());
    chk("count_le_depth", (count <= 5'(DEPTH)) ? 1 : 0, 1);
  endtask

  // One clock cycle: drive inputs, check lookups before the edge, check issue after it.
  task automatic drive(input logic v, input logic [3:0] r, input logic [15:0] d,
                       input logic st, input logic [3:0] a, input logic [3:0] b);
    in_valid = v; in_reg = r; in_dado = d; wr_stall = st; lk_regA = a; lk_regB = b;
    #2;
    check_comb();
    model_edge();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic reset_mid_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_wr_en   = 1'b0;
    m_wr_reg  = 4'h0;
    m_wr_dado = 16'h0000;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_count", count, 0);
    chk("rst_wr_reg", wr_reg, 0);
    chk("rst_wr_dado", wr_dado, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_wr_en = 1'b0; m_wr_reg = 4'h0; m_wr_dado = 16'h0000;
    rst_n = 1'b0; in_valid = 1'b0; in_reg = 4'h0; in_dado = 16'h0000;
    wr_stall = 1'b0; lk_regA = 4'h0; lk_regB = 4'h0;
    #1;
    chk("init_wr_en", wr_en, 0);
    chk("init_count", count, 0);
    chk("init_wr_reg", wr_reg, 0);
    chk("init_wr_dado", wr_dado, 0);
    chk("init_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single push, issued one edge later
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 4'd0);
    chk("s1_wait_wr_en", wr_en, 0);
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 4'd0);
    chk("s1_wr_en", wr_en, 1);
    chk("s1_wr_reg", wr_reg, 3);
    chk("s1_wr_dado", wr_dado, 16'h1234);
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 4'd0);
    chk("s1_idle_wr_en", wr_en, 0);
    chk("s1_idle_count", count, 0);

    // fill under stall, fifth push refused, then drain in order
    for (int i = 0; i < 4; i++) drive(1'b1, 4'(i + 8), 16'(16'hA000 + i), 1'b1, 4'd8, 4'd11);
    chk("s2_full_count", count, 4);
    chk("s2_full_ready", in_ready, 0);
    drive(1'b1, 4'd15, 16'hDEAD, 1'b1, 4'd15, 4'd9);
    chk("s2_ignored_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd10, 4'd15);
      chk("s2_drain_reg", wr_reg, i + 8);
      chk("s2_drain_en", wr_en, 1);
    end
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0);

    // same register pushed twice: the younger value is forwarded
    drive(1'b1, 4'd5, 16'h0001, 1'b1, 4'd5, 4'd6);
    drive(1'b1, 4'd5, 16'h0002, 1'b1, 4'd5, 4'd6);
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 4'd6);
    chk("s3_hitA", fwd_hitA, 1);
    chk("s3_dataA", fwd_dataA, 16'h0002);
    chk("s3_hitB", fwd_hitB, 0);
    chk("s3_dataB", fwd_dataB, 16'h0000);
    repeat (3) drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 4'd6);

    // sustained push every cycle without stall, pointers wrap several times
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 4'(i), 16'(16'h5000 + i), 1'b0, 4'(i), 4'(i + 1));
      chk("s4_count_le1", (count <= 5'd1) ? 1 : 0, 1);
      if (i > 0) chk("s4_order", wr_dado, 16'h5000 + i - 1);
    end
    repeat (2) drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0);

    // forwarding from the issue stage only
    drive(1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0, 4'd7);
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7);
    chk("s5_hitB", fwd_hitB, 1);
    chk("s5_dataB", fwd_dataB, 16'hBEEF);
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd7);
    chk("s5_gone_hitB", fwd_hitB, 0);

    // asynchronous reset with three queued and one issuing
    for (int i = 0; i < 4; i++) drive(1'b1, 4'(i + 1), 16'(16'hC000 + i), 1'b1, 4'd1, 4'd2);
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd1, 4'd2);
    chk("s6_pre_count", count, 3);
    chk("s6_pre_wr_en", wr_en, 1);
    reset_mid_cycle();
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd3, 4'd1);
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 4'd1);
    chk("s6_post_wr_reg", wr_reg, 3);
    chk("s6_post_wr_dado", wr_dado, 16'h1234);
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 4'd1);

    // randomized traffic over a small register range to provoke forwarding
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 4'($urandom_range(0, 3)),
            16'($urandom), ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
